demux_1_4_tdm: RTL and testbench
================================

# demux_1_4_tdm

Sequential 1-to-4 time-division demultiplexer: accepts a serial stream of samples framed by a `sync` marker and distributes consecutive samples to four output lanes (slot 0..3). Each completed frame is presented as four parallel lanes. It is the receive-side counterpart of the team's 4:1 multiplexer path. It sits between a serialised link and lane-parallel consumers. It provides per-slot strobes, a frame-complete pulse and framing-error detection.

## Interface
- `WIDTH`, 8, sample width in bits (1..32)
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-high reset
- `in_valid`  input  1  sample present on `in_data` this cycle
- `in_data`  input  WIDTH  serial sample
- `sync`  input  1  qualified by `in_valid`; marks the current sample as slot 0
- `lane_strobe`  output  4  one-hot, registered; bit k pulses one cycle after slot k is accepted
- `lane_data`  output  4*WIDTH  registered frame output; lane k at bits [k*WIDTH +: WIDTH]
- `frame_valid`  output  1  one-cycle pulse; `lane_data` holds a new complete frame
- `sync_err`  output  1  one-cycle pulse; framing violation detected
- `err_cnt`  output  8  saturating count of `sync_err` events

## Operation
- State machine:
  - IDLE (after reset):
    - `in_valid` without `sync` is dropped. No strobe is issued and nothing is counted.
    - `in_valid & sync` accepts the sample as slot 0 and moves to RUN with slot=1.
  - RUN:
    - Each `in_valid` without `sync` is stored in slot `slot` and `slot` increments.
    - Accepting slot 3 completes the frame. All four staged samples go to `lane_data` at once: slot 3 is written directly, slots 0-2 come from the staging registers. `frame_valid` pulses. `slot` wraps to 0 and the state stays RUN.
    - `in_valid & sync` with slot==0 starts a normal frame. This sample is slot 0 and slot becomes 1.
    - `in_valid & sync` with slot!=0 is an early sync:
      - `sync_err` pulses and `err_cnt` increments.
      - The partial frame is discarded and `lane_data` is unchanged.
      - The current sample becomes slot 0 and slot becomes 1.
    - `in_valid` without `sync` at slot==0 is a frame continuation without a marker. It is legal and is accepted as slot 0, so only the first frame needs `sync`.
  - `in_valid`=0 means no state change, so gaps of any length are permitted mid-frame.
- `lane_strobe[k]` pulses for every accepted sample in slot k, including samples of frames later discarded by an early sync. `lane_strobe` is never asserted in IDLE.
- `lane_data` changes only on frame completion. Between frames it holds the last complete frame.
- `err_cnt` saturates at 8'hFF.
- Reset values:
  - state=IDLE, slot=0
  - `lane_strobe`=4'b0, `lane_data`=0, `frame_valid`=0, `sync_err`=0, `err_cnt`=0
  - staging registers cleared
- A reset asserted mid-frame abandons the partial frame immediately (asynchronously). After release the block behaves exactly as after power-up, including the return to IDLE and waiting for `sync`.

## Timing
- All outputs are registered. Throughput is one sample per clock with no back-pressure.
- Latency from the `in_valid` cycle accepting slot k to `lane_strobe[k]` is 1 clock.
- Latency from the slot-3 accept cycle to `frame_valid` and the new `lane_data` is 1 clock. Both update on the same edge.
- Latency from the early-sync accept cycle to `sync_err` and the `err_cnt` update is 1 clock. `lane_strobe[0]` pulses on that same edge.
- Back-to-back frames give `frame_valid` once every 4 clocks, with no idle cycle needed between frames.
- Reset assertion forces all outputs to their reset values without a clock edge. Deassertion is synchronous to the design and is applied at least one cycle before the first `in_valid`.

## Test plan
- Reset, then `sync`+0x11, 0x22, 0x33, 0x44 on consecutive cycles:
  - `lane_strobe` = 0001, 0010, 0100, 1000 on successive cycles.
  - `frame_valid` pulses once, one cycle after 0x44.
  - `lane_data` = {0x44,0x33,0x22,0x11}.
- Idle drop: in IDLE send 0xAA, 0xBB without `sync` -> no strobes, `lane_data` stays 0. The following `sync`-led frame is captured normally.
- Continuous frames with gaps: first frame led by `sync`, second frame 0x55..0x88 with no `sync` and 2-cycle gaps between samples:
  - Second `frame_valid` arrives with `lane_data`={0x88,0x77,0x66,0x55}.
  - `sync_err` stays 0.
- Early sync: `sync`+0x01, 0x02, then `sync`+0x10, 0x20, 0x30, 0x40:
  - `sync_err` pulses one cycle after the second `sync` and `err_cnt`=1.
  - `frame_valid` pulses once, with `lane_data`={0x40,0x30,0x20,0x10}.
- Saturation: 300 early-sync events -> `err_cnt` reaches 0xFF and holds.
- Reset mid-frame: accept slots 0-1, assert `rst` for 1 cycle, then send 0x99 without `sync`:
  - No strobe and no `frame_valid`.
  - All outputs at reset values and the state is IDLE.

Source files
------------

// File: rtl/demux_1_4_tdm.sv
// demux_1_4_tdm -- 1:4 time-division demultiplexer.
// Splits a sync-framed serial sample stream into four parallel lanes.
// Ports:
//   clk, rst                   clock, async active-high reset
//   in_valid, in_data, sync    serial input; sync marks slot 0
//   lane_strobe[3:0]           one-hot pulse, one cycle after slot k is accepted
//   lane_data[4*WIDTH-1:0]     last complete frame; lane k at [k*WIDTH +: WIDTH]
//   frame_valid                pulse when lane_data takes a new frame
//   sync_err, err_cnt          early-sync pulse and its saturating count

// One lane: a staging register plus the frame output register.
// The last slot (DIRECT) loads the live sample instead of its stage,
// so the frame is published on the same edge that accepts slot 3.
module demux_lane #(
  parameter int WIDTH  = 8,
  parameter bit DIRECT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stage_en,
  input  logic             load_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] stage;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage <= '0;
      q     <= '0;
    end else begin
      if (stage_en) stage <= din;
      if (load_en)  q     <= DIRECT ? din : stage;
    end
  end
endmodule

module demux_1_4_tdm #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               sync,
  output logic [3:0]         lane_strobe,
  output logic [4*WIDTH-1:0] lane_data,
  output logic               frame_valid,
  output logic               sync_err,
  output logic [7:0]         err_cnt
);
  typedef enum logic {IDLE, RUN} state_t;

  state_t     state;
  logic [1:0] slot;      // next slot to fill
  logic [1:0] slot_acc;  // slot the current sample lands in
  logic [3:0] slot_hot;
  logic       acc, early, complete;

  // IDLE only accepts a sync-led sample; RUN accepts everything.
  assign acc      = in_valid & (sync | (state == RUN));
  // sync always restarts the frame at slot 0
  assign slot_acc = sync ? 2'd0 : slot;
  assign slot_hot = acc ? (4'b0001 << slot_acc) : 4'b0000;
  assign early    = in_valid & sync & (state == RUN) & (slot != 2'd0);
  assign complete = acc & (slot_acc == 2'd3);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      slot        <= 2'd0;
      lane_strobe <= 4'b0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      err_cnt     <= 8'h00;
    end else begin
      lane_strobe <= slot_hot;
      frame_valid <= complete;
      sync_err    <= early;
      if (early && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
      if (acc) begin
        state <= RUN;
        slot  <= slot_acc + 2'd1;  // wraps 3 -> 0 on completion
      end
    end
  end

  // An early sync simply overwrites stage 0 and never raises complete,
  // so the partial frame is dropped and lane_data is untouched.
  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_lane
      demux_lane #(.WIDTH(WIDTH), .DIRECT(k == 3)) u_lane (
        .clk      (clk),
        .rst      (rst),
        .stage_en (slot_hot[k]),
        .load_en  (complete),
        .din      (in_data),
        .q        (lane_data[k*WIDTH +: WIDTH])
      );
    end
  endgenerate
endmodule

// File: tb/tb_demux_1_4_tdm.sv
module tb_demux_1_4_tdm;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        sync = 1'b0;
  logic [3:0]  lane_strobe;
  logic [31:0] lane_data;
  logic        frame_valid;
  logic        sync_err;
  logic [7:0]  err_cnt;

  int nchk = 0;
  int nfail = 0;
  bit started = 1'b0;

  demux_1_4_tdm #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .sync(sync),
    .lane_strobe(lane_strobe), .lane_data(lane_data), .frame_valid(frame_valid),
    .sync_err(sync_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: samples of the frame in progress sit in a queue;
  // four of them make a frame, a sync arriving on a non-empty queue is
  // an error that throws the queue away.
  logic [7:0]  q[$];
  bit          m_run;
  logic [3:0]  m_strobe;
  logic [31:0] m_data;
  logic        m_fv, m_err;
  int          m_cnt;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_run = 0; m_strobe = 0; m_data = 0; m_fv = 0; m_err = 0; m_cnt = 0;
    end else begin
      m_strobe = 0; m_fv = 0; m_err = 0;
      if (in_valid && (m_run || sync)) begin
        if (sync && q.size() != 0) begin
          m_err = 1;
          if (m_cnt < 255) m_cnt++;
          q.delete();
        end
        m_strobe = 4'(1 << q.size());
        q.push_back(in_data);
        m_run = 1;
        if (q.size() == 4) begin
          m_data = {q[3], q[2], q[1], q[0]};
          m_fv = 1;
          q.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("mdl_strobe", {28'b0, lane_strobe}, {28'b0, m_strobe});
      chk("mdl_data", lane_data, m_data);
      chk("mdl_fv", {31'b0, frame_valid}, {31'b0, m_fv});
      chk("mdl_err", {31'b0, sync_err}, {31'b0, m_err});
      chk("mdl_cnt", {24'b0, err_cnt}, 32'(m_cnt));
    end
  end

  // one clock of stimulus; returns #1 after the edge that sampled it
  task automatic cyc(input logic v, input logic s, input logic [7:0] d);
    in_valid = v; sync = s; in_data = d;
    @(posedge clk); #1;
    in_valid = 0; sync = 0;
  endtask

  initial begin
    #2 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    started = 1;
    chk("rst_strobe", {28'b0, lane_strobe}, 32'h0);
    chk("rst_data", lane_data, 32'h0);
    chk("rst_cnt", {24'b0, err_cnt}, 32'h0);
    cyc(0, 0, 0);

    // idle drop
    cyc(1, 0, 8'hAA); chk("idle_strobe_a", {28'b0, lane_strobe}, 32'h0);
    cyc(1, 0, 8'hBB); chk("idle_strobe_b", {28'b0, lane_strobe}, 32'h0);
    chk("idle_data", lane_data, 32'h0);

    // first frame
    cyc(1, 1, 8'h11); chk("f1_s0", {28'b0, lane_strobe}, 32'h1);
    cyc(1, 0, 8'h22); chk("f1_s1", {28'b0, lane_strobe}, 32'h2);
    cyc(1, 0, 8'h33); chk("f1_s2", {28'b0, lane_strobe}, 32'h4);
    chk("f1_fv_early", {31'b0, frame_valid}, 32'h0);
    cyc(1, 0, 8'h44); chk("f1_s3", {28'b0, lane_strobe}, 32'h8);
    chk("f1_fv", {31'b0, frame_valid}, 32'h1);
    chk("f1_data", lane_data, 32'h44332211);

    // continuation frame without sync, 2-cycle gaps
    cyc(1, 0, 8'h55); chk("f2_fv_clear", {31'b0, frame_valid}, 32'h0);
    cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(1, 0, 8'h66); cyc(0, 0, 0); cyc(0, 0, 0);
    cyc(1, 0, 8'h77); cyc(0, 0, 0); cyc(0, 0, 0);
    chk("f2_hold", lane_data, 32'h44332211);
    cyc(1, 0, 8'h88);
    chk("f2_fv", {31'b0, frame_valid}, 32'h1);
    chk("f2_data", lane_data, 32'h88776655);
    chk("f2_err", {31'b0, sync_err}, 32'h0);
    cyc(0, 0, 0);

    // early sync
    cyc(1, 1, 8'h01); cyc(1, 0, 8'h02);
    cyc(1, 1, 8'h10);
    chk("es_err", {31'b0, sync_err}, 32'h1);
    chk("es_cnt", {24'b0, err_cnt}, 32'h1);
    chk("es_strobe", {28'b0, lane_strobe}, 32'h1);
    chk("es_hold", lane_data, 32'h88776655);
    cyc(1, 0, 8'h20); chk("es_err_clr", {31'b0, sync_err}, 32'h0);
    cyc(1, 0, 8'h30); cyc(1, 0, 8'h40);
    chk("es_fv", {31'b0, frame_valid}, 32'h1);
    chk("es_data", lane_data, 32'h40302010);

    // saturation: 300 early syncs on top of the existing count
    for (int i = 0; i < 301; i++) begin
      cyc(1, 1, 8'(i));
      cyc(1, 0, 8'(i + 1));
    end
    chk("sat_cnt", {24'b0, err_cnt}, 32'hFF);
    cyc(1, 1, 8'hC0);
    chk("sat_err", {31'b0, sync_err}, 32'h1);
    chk("sat_hold", {24'b0, err_cnt}, 32'hFF);

    // reset mid-frame
    cyc(1, 0, 8'hD0);  // slot 1 after the sync above
    rst = 1;
    #1;
    chk("arst_strobe", {28'b0, lane_strobe}, 32'h0);
    chk("arst_data", lane_data, 32'h0);
    chk("arst_cnt", {24'b0, err_cnt}, 32'h0);
    @(posedge clk); #1 rst = 0;
    cyc(0, 0, 0);
    cyc(1, 0, 8'h99);
    chk("post_strobe", {28'b0, lane_strobe}, 32'h0);
    chk("post_fv", {31'b0, frame_valid}, 32'h0);
    cyc(1, 0, 8'h9A); cyc(1, 0, 8'h9B); cyc(1, 0, 8'h9C);
    chk("post_data", lane_data, 32'h0);
    chk("post_strobe2", {28'b0, lane_strobe}, 32'h0);
    // back in IDLE: a sync-led frame is captured from scratch
    cyc(1, 1, 8'hA1); chk("post_s0", {28'b0, lane_strobe}, 32'h1);
    cyc(1, 0, 8'hA2); cyc(1, 0, 8'hA3); cyc(1, 0, 8'hA4);
    chk("post_frame", lane_data, 32'hA4A3A2A1);
    chk("post_err", {24'b0, err_cnt}, 32'h0);
    cyc(0, 0, 0); cyc(0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
